// File: rtl/keypad_entry_pkg.sv
// Shared key-code constants, commit-cause encodings and FSM state type for keypad_entry.
package keypad_entry_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_HASH = 4'd14;
    localparam logic [3:0] KEY_STAR = 4'd15;

    localparam logic [2:0] OP_A     = 3'd0;
    localparam logic [2:0] OP_B     = 3'd1;
    localparam logic [2:0] OP_C     = 3'd2;
    localparam logic [2:0] OP_D     = 3'd3;
    localparam logic [2:0] OP_ENTER = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Only meaningful for the commit keys A-D and '#'.
    function automatic logic [2:0] key_to_op(input logic [3:0] k);
        logic [2:0] op;
        op = OP_A;
        case (k)
            KEY_A:    op = OP_A;
            KEY_B:    op = OP_B;
            KEY_C:    op = OP_C;
            KEY_D:    op = OP_D;
            KEY_HASH: op = OP_ENTER;
            default:  op = OP_A;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/bcd4_to_bin.sv
// Combinational 4-digit BCD to 14-bit binary converter (max 9999).
// Only compiled when KEYPAD_ENTRY_BIN_EN is defined.
`ifdef KEYPAD_ENTRY_BIN_EN
module bcd4_to_bin (
    input  logic [15:0] bcd_i,
    output logic [13:0] bin_o
);

    logic [13:0] d3, d2, d1, d0;

    assign d3 = 14'(bcd_i[15:12]);
    assign d2 = 14'(bcd_i[11:8]);
    assign d1 = 14'(bcd_i[7:4]);
    assign d0 = 14'(bcd_i[3:0]);

    // 9999 fits in 14 bits, so no intermediate product can overflow.
    assign bin_o = d3 * 14'd1000 + d2 * 14'd100 + d1 * 14'd10 + d0;

endmodule
`endif

// File: rtl/keypad_entry.sv
// Keypad operand entry: collects up to MAX_DIGITS BCD digits, commits on A-D/'#', holds until accepted.
// Define KEYPAD_ENTRY_BIN_EN to drive out_bin with the binary value of out_bcd (otherwise tied to 0).
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int MAX_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_code,
    input  logic        key_valid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_bcd,
    output logic [2:0]  out_op,
    output logic [13:0] out_bin,
    output logic [15:0] entry_bcd,
    output logic [2:0]  digit_count,
    output logic        key_dropped
);

    localparam logic [2:0] MAXC = 3'(MAX_DIGITS);

    state_e      state_q, state_d;
    logic [15:0] entry_q, entry_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] obcd_q, obcd_d;
    logic [2:0]  op_q, op_d;
    logic        drop_q, drop_d;
    logic        is_digit;

    assign is_digit = (key_code <= KEY_9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            entry_q <= '0;
            count_q <= '0;
            obcd_q  <= '0;
            op_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            count_q <= count_d;
            obcd_q  <= obcd_d;
            op_q    <= op_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        count_d = count_q;
        obcd_d  = obcd_q;
        op_d    = op_q;
        drop_d  = 1'b0;
        case (state_q)
            HOLD: begin
                // Every strobe seen while holding is lost, even on the accept cycle.
                if (key_valid) drop_d = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: begin
                if (key_valid) begin
                    if (is_digit) begin
                        if (count_q < MAXC) begin
                            entry_d = {entry_q[11:0], key_code};
                            count_d = count_q + 3'd1;
                            state_d = ENTRY;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end else if (key_code == KEY_STAR) begin
                        entry_d = '0;
                        count_d = '0;
                        state_d = IDLE;
                    end else begin
                        obcd_d  = entry_q;
                        op_d    = key_to_op(key_code);
                        entry_d = '0;
                        count_d = '0;
                        state_d = HOLD;
                    end
                end
            end
        endcase
    end

    assign out_valid   = (state_q == HOLD);
    assign out_bcd     = obcd_q;
    assign out_op      = op_q;
    assign entry_bcd   = entry_q;
    assign digit_count = count_q;
    assign key_dropped = drop_q;

`ifdef KEYPAD_ENTRY_BIN_EN
    bcd4_to_bin u_bin (
        .bcd_i (obcd_q),
        .bin_o (out_bin)
    );
`else
    assign out_bin = '0;
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: directed scenarios plus randomized keys against a digit-queue model.
module tb_keypad_entry;

    localparam int MAXD = 4;
`ifdef KEYPAD_ENTRY_BIN_EN
    localparam bit BIN_EN = 1'b1;
`else
    localparam bit BIN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key_code = '0;
    logic        key_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_bcd;
    logic [2:0]  out_op;
    logic [13:0] out_bin;
    logic [15:0] entry_bcd;
    logic [2:0]  digit_count;
    logic        key_dropped;

    int nvec  = 0;
    int nfail = 0;

    // Reference model: typed digits as a queue, committed operand as a plain integer.
    int m_digits[$];
    bit m_hold;
    int m_val;
    int m_op;
    bit m_drop;

    keypad_entry #(.MAX_DIGITS(MAXD)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bcd     (out_bcd),
        .out_op      (out_op),
        .out_bin     (out_bin),
        .entry_bcd   (entry_bcd),
        .digit_count (digit_count),
        .key_dropped (key_dropped)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_digits.delete();
        m_hold = 1'b0;
        m_val  = 0;
        m_op   = 0;
        m_drop = 1'b0;
    endtask

    task automatic model_edge(input bit kv, input int code, input bit rdy);
        m_drop = 1'b0;
        if (m_hold) begin
            if (kv) m_drop = 1'b1;
            if (rdy) m_hold = 1'b0;
        end else if (kv) begin
            if (code <= 9) begin
                if (m_digits.size() < MAXD) m_digits.push_back(code);
                else m_drop = 1'b1;
            end else if (code == 15) begin
                m_digits.delete();
            end else begin
                m_val = 0;
                foreach (m_digits[i]) m_val = m_val * 10 + m_digits[i];
                m_op   = (code == 14) ? 4 : code - 10;
                m_hold = 1'b1;
                m_digits.delete();
            end
        end
    endtask

    task automatic step(input bit kv, input int code, input bit rdy);
        key_valid = kv;
        key_code  = 4'(code);
        out_ready = rdy;
        @(posedge clk);
        model_edge(kv, code, rdy);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        nvec++;
        if ({out_valid, key_dropped, out_bcd, out_op, entry_bcd, digit_count} !== '0) begin
            nfail++;
            $display("FAIL reset_state: valid=%b drop=%b bcd=%h op=%0d entry=%h cnt=%0d, want all 0",
                     out_valid, key_dropped, out_bcd, out_op, entry_bcd, digit_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_enter();
        step(1, 1, 1); step(1, 2, 1); step(1, 3, 1);
        nvec++;
        if (entry_bcd !== 16'h0123 || digit_count !== 3'd3) begin
            nfail++; $display("FAIL enter_entry: entry=%h cnt=%0d want 0123 3", entry_bcd, digit_count);
        end
        step(1, 14, 1);
        nvec++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h0123 || out_op !== 3'd4) begin
            nfail++; $display("FAIL enter_commit: valid=%b bcd=%h op=%0d want 1 0123 4", out_valid, out_bcd, out_op);
        end
        nvec++;
        if (out_bin !== (BIN_EN ? 14'd123 : 14'd0)) begin
            nfail++; $display("FAIL enter_bin: got %0d want %0d", out_bin, BIN_EN ? 123 : 0);
        end
        nvec++;
        if (entry_bcd !== 16'h0 || digit_count !== 3'd0) begin
            nfail++; $display("FAIL enter_clear: entry=%h cnt=%0d want 0 0", entry_bcd, digit_count);
        end
        step(0, 0, 1);
        nvec++;
        if (out_valid !== 1'b0) begin
            nfail++; $display("FAIL enter_release: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_overflow();
        step(1, 9, 0); step(1, 8, 0); step(1, 7, 0); step(1, 6, 0);
        step(1, 5, 0);
        nvec++;
        if (key_dropped !== 1'b1 || entry_bcd !== 16'h9876 || digit_count !== 3'd4) begin
            nfail++; $display("FAIL overflow_drop: drop=%b entry=%h cnt=%0d want 1 9876 4",
                              key_dropped, entry_bcd, digit_count);
        end
        step(0, 0, 0);
        nvec++;
        if (key_dropped !== 1'b0 || entry_bcd !== 16'h9876) begin
            nfail++; $display("FAIL overflow_pulse: drop=%b entry=%h want 0 9876", key_dropped, entry_bcd);
        end
        step(1, 15, 0);
        nvec++;
        if (entry_bcd !== 16'h0 || digit_count !== 3'd0 || key_dropped !== 1'b0) begin
            nfail++; $display("FAIL star_clear: entry=%h cnt=%0d drop=%b want 0 0 0", entry_bcd, digit_count, key_dropped);
        end
    endtask

    task automatic test_star();
        step(1, 4, 0); step(1, 2, 0); step(1, 15, 0); step(1, 7, 0);
        step(1, 11, 0);
        nvec++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h0007 || out_op !== 3'd1) begin
            nfail++; $display("FAIL star_commit: valid=%b bcd=%h op=%0d want 1 0007 1", out_valid, out_bcd, out_op);
        end
        nvec++;
        if (out_bin !== (BIN_EN ? 14'd7 : 14'd0)) begin
            nfail++; $display("FAIL star_bin: got %0d want %0d", out_bin, BIN_EN ? 7 : 0);
        end
        step(0, 0, 1);
    endtask

    task automatic test_hold();
        step(1, 5, 0);
        step(1, 10, 0);
        for (int i = 0; i < 10; i++) begin
            step(i == 4, 3, 0);
            nvec++;
            if (out_valid !== 1'b1 || out_bcd !== 16'h0005 || out_op !== 3'd0 || entry_bcd !== 16'h0
                || key_dropped !== (i == 4)) begin
                nfail++; $display("FAIL hold_stable[%0d]: valid=%b bcd=%h op=%0d entry=%h drop=%b want 1 0005 0 0 %b",
                                  i, out_valid, out_bcd, out_op, entry_bcd, key_dropped, i == 4);
            end
        end
        step(1, 3, 1);
        nvec++;
        if (out_valid !== 1'b0 || key_dropped !== 1'b1 || entry_bcd !== 16'h0 || digit_count !== 3'd0) begin
            nfail++; $display("FAIL hold_handshake: valid=%b drop=%b entry=%h cnt=%0d want 0 1 0 0",
                              out_valid, key_dropped, entry_bcd, digit_count);
        end
        step(0, 0, 0);
        nvec++;
        if (key_dropped !== 1'b0 || out_valid !== 1'b0) begin
            nfail++; $display("FAIL hold_idle: drop=%b valid=%b want 0 0", key_dropped, out_valid);
        end
    endtask

    task automatic test_idle_commit_reset();
        step(1, 13, 0);
        nvec++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h0 || out_op !== 3'd3) begin
            nfail++; $display("FAIL idle_commit: valid=%b bcd=%h op=%0d want 1 0000 3", out_valid, out_bcd, out_op);
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (out_valid !== 1'b0 || digit_count !== 3'd0 || out_op !== 3'd0 || key_dropped !== 1'b0) begin
            nfail++; $display("FAIL async_reset: valid=%b cnt=%0d op=%0d drop=%b want 0 0 0 0",
                              out_valid, digit_count, out_op, key_dropped);
        end
        #2 rst = 1'b0;
        model_reset();
        step(1, 8, 0);
        nvec++;
        if (entry_bcd !== 16'h0008 || digit_count !== 3'd1) begin
            nfail++; $display("FAIL post_reset_key: entry=%h cnt=%0d want 0008 1", entry_bcd, digit_count);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_entry, exp_bcd;
        bit kv, rdy;
        int code;
        rst = 1'b1; #1; rst = 1'b0;
        model_reset();
        for (int n = 0; n < 800; n++) begin
            kv   = ($urandom_range(0, 2) != 0);
            code = ($urandom_range(0, 2) != 0) ? $urandom_range(0, 9) : $urandom_range(10, 15);
            rdy  = ($urandom_range(0, 3) == 0);
            step(kv, code, rdy);
            exp_entry = '0;
            foreach (m_digits[i]) exp_entry = (exp_entry << 4) | 16'(m_digits[i]);
            exp_bcd = 16'(((m_val / 1000) % 10) * 4096 + ((m_val / 100) % 10) * 256
                          + ((m_val / 10) % 10) * 16 + m_val % 10);
            nvec++;
            if (out_valid !== m_hold || key_dropped !== m_drop || entry_bcd !== exp_entry
                || digit_count !== 3'(m_digits.size())) begin
                nfail++; $display("FAIL rand_state[%0d]: valid=%b drop=%b entry=%h cnt=%0d want %b %b %h %0d",
                                  n, out_valid, key_dropped, entry_bcd, digit_count,
                                  m_hold, m_drop, exp_entry, m_digits.size());
            end
            if (m_hold) begin
                nvec++;
                if (out_bcd !== exp_bcd || out_op !== 3'(m_op) || out_bin !== (BIN_EN ? 14'(m_val) : 14'd0)) begin
                    nfail++; $display("FAIL rand_out[%0d]: bcd=%h op=%0d bin=%0d want %h %0d %0d",
                                      n, out_bcd, out_op, out_bin, exp_bcd, m_op, BIN_EN ? m_val : 0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_enter();
        test_overflow();
        test_star();
        test_hold();
        test_idle_commit_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 4, legal range 1..4: maximum decimal digits per operand.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port key_code, input, 4, key code from the scanner: 0-9 are digits, 10-13 are A-D, 14 is '#', 15 is '*'.
REQ-005 SHALL have port key_valid, input, 1, one-cycle strobe qualifying key_code.
REQ-006 SHALL have port out_valid, output, 1, committed operand available.
REQ-007 SHALL have port out_ready, input, 1, consumer accepts the operand.
REQ-008 SHALL have port out_bcd, output, 16, committed operand as 4 BCD nibbles, least significant digit in [3:0].
REQ-009 SHALL have port out_op, output, 3, commit cause: 0-3 = A-D, 4 = '#' enter.
REQ-010 SHALL have port out_bin, output, 14, binary value of out_bcd.
REQ-011 SHALL have port entry_bcd, output, 16, live digits being typed, for display.
REQ-012 SHALL have port digit_count, output, 3, number of digits in entry_bcd.
REQ-013 SHALL have port key_dropped, output, 1, one-cycle pulse when an accepted strobe is discarded.

Function
REQ-014 SHALL implement FSM states IDLE (count 0), ENTRY (count 1..MAX_DIGITS) and HOLD (out_valid high).
REQ-015 In IDLE or ENTRY, when key_valid is high and key_code is 0-9 with count < MAX_DIGITS, the block SHALL, in the next cycle:
- shift entry_bcd left one nibble;
- insert the new digit in [3:0];
- increment the count;
- enter ENTRY.
REQ-016 A digit received at count == MAX_DIGITS SHALL be ignored and SHALL pulse key_dropped.
REQ-017 Key '*' SHALL clear entry_bcd and the count to 0 and enter IDLE in the next cycle.
REQ-018 Keys A-D and '#' in IDLE or ENTRY SHALL, in the next cycle:
- copy entry_bcd into out_bcd;
- set out_op;
- assert out_valid;
- clear entry_bcd and the count;
- enter HOLD.
REQ-019 A commit from IDLE SHALL commit the value 0.
REQ-020 In HOLD, out_bcd, out_op and out_valid SHALL stay stable until out_valid && out_ready.
REQ-021 When out_valid && out_ready, the block SHALL deassert out_valid in the next cycle and return to IDLE.
REQ-022 Any key_valid while in HOLD SHALL be discarded and SHALL pulse key_dropped, including a strobe in the handshake cycle itself.
REQ-023 Commit latency SHALL be 1 cycle from key_valid to out_valid.
REQ-024 There SHALL be no combinational path from key_valid to any output.
REQ-025 out_bin SHALL be combinational from registered out_bcd, valid in the same cycle as out_valid, with maximum value 9999.

Reset
REQ-026 Asserting rst SHALL immediately force the following, including mid-entry and mid-HOLD:
- state IDLE;
- out_valid 0, key_dropped 0;
- out_bcd 0, out_op 0;
- entry_bcd 0, digit_count 0.
REQ-027 The first key_valid sampled after rst deasserts SHALL be processed normally.

Configuration
REQ-028 Macro KEYPAD_ENTRY_BIN_EN SHALL control binary conversion:
- when defined, out_bin carries the BCD-to-binary conversion;
- when undefined, no conversion logic is compiled and out_bin is tied to 0;
- the port list SHALL be identical in both cases.

Structure
REQ-029 A shared package SHALL hold:
- the key-code constants (KEY_0..KEY_9, KEY_A..KEY_D, KEY_HASH=14, KEY_STAR=15);
- the out_op encodings;
- the FSM state typedef.
REQ-030 The conversion SHALL be a sub-module bcd4_to_bin: purely combinational, 16-bit BCD in, 14-bit binary out.

Verification
REQ-031 Keys 1,2,3 then '#' with out_ready=1 -> out_valid 1 cycle after '#', out_bcd=0x0123, out_op=4, out_bin=123 (macro defined) or 0 (undefined).
REQ-032 Keys 9,8,7,6,5 -> fifth digit dropped with key_dropped pulse, entry_bcd=0x9876, digit_count=4.
REQ-033 Keys 4,2 then '*' then 7 and 'B' -> out_bcd=0x0007, out_op=1.
REQ-034 Key 5 then 'A' with out_ready=0 for 10 cycles, key 3 during HOLD -> outputs stable, key_dropped pulse, entry_bcd stays 0; after out_ready=1, IDLE.
REQ-035 Key 'D' from IDLE -> out_bcd=0, out_op=3; rst pulsed during HOLD -> out_valid 0 immediately, digit_count 0.
